// File: rtl/fb_write_scheduler_if.sv
// Frame-buffer write-port scheduling bus between the frame manager and the draw sources.
// The master side is the scheduler; the slave side is the frame manager / draw units.
interface fb_write_scheduler_if #(
    parameter int NUM_SOURCES = 2,
    parameter int SEL_WIDTH   = 1
);
    logic                   frame;
    logic [NUM_SOURCES-1:0] src_req;
    logic [NUM_SOURCES-1:0] src_done;
    logic [NUM_SOURCES-1:0] src_grant;
    logic [SEL_WIDTH-1:0]   write_source_sel;
    logic                   sched_busy;
    logic                   frame_done;
    logic [7:0]             overrun_cnt;
    logic                   timeout_flag;

    modport master (
        input  frame, src_req, src_done,
        output src_grant, write_source_sel, sched_busy,
        output frame_done, overrun_cnt, timeout_flag
    );

    modport slave (
        output frame, src_req, src_done,
        input  src_grant, write_source_sel, sched_busy,
        input  frame_done, overrun_cnt, timeout_flag
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// Per-frame sequencer granting the shared frame-buffer write port to each requesting source.
// Optional per-grant watchdog enabled by defining FB_SCHED_WATCHDOG_EN.
module fb_write_scheduler #(
    parameter int NUM_SOURCES     = 2,
    parameter int SEL_WIDTH       = 1,
    parameter int WATCHDOG_CYCLES = 400000
) (
    input  logic                 clk,
    input  logic                 resetN,
    fb_write_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, CHECK, GRANT, NEXT} state_t;

    localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(NUM_SOURCES - 1);

    if ((2 ** SEL_WIDTH) < NUM_SOURCES || WATCHDOG_CYCLES < 2) begin : g_bad_params
        $error("fb_write_scheduler: inconsistent parameters");
    end

    state_t                 state, state_nx;
    logic [SEL_WIDTH-1:0]   idx, idx_nx;
    logic [NUM_SOURCES-1:0] grant_nx;
    logic [SEL_WIDTH-1:0]   sel_nx;
    logic                   busy_nx;
    logic                   fdone_nx;
    logic [7:0]             ovr_nx;
    logic                   wd_expire;

`ifdef FB_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(WATCHDOG_CYCLES);

    logic [WDW-1:0] wd_cnt;

    // Counter sits at zero outside GRANT, so it is clear on every grant entry.
    always_ff @(posedge clk) begin
        if (!resetN || state != GRANT)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_expire = (state == GRANT) && !bus.src_done[idx] &&
                       (wd_cnt == WDW'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!resetN)
            bus.timeout_flag <= 1'b0;
        else if (wd_expire)
            bus.timeout_flag <= 1'b1;
    end
`else
    assign wd_expire        = 1'b0;
    assign bus.timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state                <= IDLE;
            idx                  <= '0;
            bus.src_grant        <= '0;
            bus.write_source_sel <= '0;
            bus.sched_busy       <= 1'b0;
            bus.frame_done       <= 1'b0;
            bus.overrun_cnt      <= '0;
        end else begin
            state                <= state_nx;
            idx                  <= idx_nx;
            bus.src_grant        <= grant_nx;
            bus.write_source_sel <= sel_nx;
            bus.sched_busy       <= busy_nx;
            bus.frame_done       <= fdone_nx;
            bus.overrun_cnt      <= ovr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        unique case (state)
            IDLE: begin
                if (bus.frame) begin
                    state_nx = CHECK;
                    idx_nx   = '0;
                end
            end
            CHECK: begin
                state_nx = bus.src_req[idx] ? GRANT : NEXT;
            end
            GRANT: begin
                if (bus.src_done[idx] || wd_expire)
                    state_nx = NEXT;
            end
            NEXT: begin
                if (idx == LAST) begin
                    state_nx = IDLE;
                end else begin
                    idx_nx   = idx + 1'b1;
                    state_nx = CHECK;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output values for the next edge; all outputs leave through registers.
    always_comb begin
        grant_nx = '0;
        sel_nx   = bus.write_source_sel;
        busy_nx  = (state_nx != IDLE);
        fdone_nx = (state == NEXT) && (state_nx == IDLE);
        ovr_nx   = bus.overrun_cnt;
        if (state_nx == GRANT)
            grant_nx = NUM_SOURCES'(1) << idx;
        if (state == CHECK && state_nx == GRANT)
            sel_nx = idx;
        if (bus.frame && state != IDLE && bus.overrun_cnt != 8'hFF)
            ovr_nx = bus.overrun_cnt + 8'd1;
    end
endmodule
